// File: rtl/matmul_job_scheduler_if.sv
// Control and lane bus for matmul_job_scheduler.
//   start_stb/start_ack : begin-product handshake
//   lane_go/lane_row/lane_col : per-lane job issue (row/col slice [i*IW +: IW])
//   lane_done           : per-lane completion pulses
//   done_stb/done_ack   : product-complete handshake
//   busy, jobs_done, err: status
// master = controller / lane array side, slave = scheduler side.
interface matmul_job_scheduler_if #(
  parameter int unsigned n = 10,
  parameter int unsigned m = 4
);
  localparam int unsigned IW = (n > 1) ? $clog2(n) : 1;
  localparam int unsigned CW = $clog2(n * n + 1);

  logic              start_stb;
  logic              start_ack;
  logic [m-1:0]      lane_go;
  logic [m*IW-1:0]   lane_row;
  logic [m*IW-1:0]   lane_col;
  logic [m-1:0]      lane_done;
  logic              done_stb;
  logic              done_ack;
  logic              busy;
  logic [CW-1:0]     jobs_done;
  logic              err;

  modport master (
    output start_stb, lane_done, done_ack,
    input  start_ack, lane_go, lane_row, lane_col, done_stb, busy, jobs_done, err
  );

  modport slave (
    input  start_stb, lane_done, done_ack,
    output start_ack, lane_go, lane_row, lane_col, done_stb, busy, jobs_done, err
  );
endinterface

// File: rtl/matmul_job_scheduler.sv
// Sequences one n x n matrix product over m dot-product lanes: after a start
// handshake, issues the n*n (row,col) jobs in row-major order to free lanes
// (round-robin search), counts completions and raises done_stb until done_ack.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : matmul_job_scheduler_if.slave (handshakes, lane issue/done, status)
module matmul_job_scheduler #(
  parameter int unsigned n = 10,
  parameter int unsigned m = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  matmul_job_scheduler_if.slave bus
);
  localparam int unsigned IW = (n > 1) ? $clog2(n) : 1;
  localparam int unsigned CW = $clog2(n * n + 1);
  localparam int unsigned RW = (m > 1) ? $clog2(m) : 1;
  localparam logic [CW-1:0] NN   = CW'(n * n);
  localparam logic [IW-1:0] LAST = IW'(n - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DISPATCH = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]      state;
  logic [m-1:0]    lane_busy;
  logic [m-1:0]    lane_go;
  logic [m*IW-1:0] lane_row;
  logic [m*IW-1:0] lane_col;
  logic [RW-1:0]   rr;
  logic [IW-1:0]   job_r;
  logic [IW-1:0]   job_c;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   jobs_done;
  logic            err;

  logic            start_fire;
  logic            grant_vld;
  logic [RW-1:0]   grant_idx;
  logic            issue;
  logic            last_issue;
  logic [m-1:0]    grant;
  logic [m-1:0]    done_hit;
  logic [m-1:0]    done_stray;
  logic [CW-1:0]   done_cnt;
  logic [CW-1:0]   jobs_done_nxt;

  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base, input int unsigned k);
    return RW'((32'(base) + k) % m);
  endfunction

  assign start_fire = bus.start_stb && (state == IDLE);

  // Round-robin search from rr over the registered busy bits, so a lane
  // released by lane_done this cycle only becomes eligible next cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < m; k++) begin
      if (!grant_vld && !lane_busy[wrap_add(rr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_add(rr, k);
      end
    end
  end

  assign issue      = (state == DISPATCH) && grant_vld;
  assign last_issue = issue && (issued == NN - CW'(1));

  always_comb begin
    grant = '0;
    for (int unsigned l = 0; l < m; l++) begin
      grant[l] = issue && (grant_idx == RW'(l));
    end
  end

  assign done_hit   = bus.lane_done & lane_busy;
  assign done_stray = bus.lane_done & ~lane_busy;

  always_comb begin
    done_cnt = '0;
    for (int unsigned l = 0; l < m; l++) begin
      done_cnt = done_cnt + CW'(done_hit[l]);
    end
  end

  assign jobs_done_nxt = jobs_done + done_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lane_busy <= '0;
      lane_go   <= '0;
      lane_row  <= '0;
      lane_col  <= '0;
      rr        <= '0;
      job_r     <= '0;
      job_c     <= '0;
      issued    <= '0;
      jobs_done <= '0;
      err       <= 1'b0;
    end else begin
      lane_go   <= grant;
      lane_busy <= (lane_busy & ~done_hit) | grant;
      jobs_done <= jobs_done_nxt;
      if (|done_stray) begin
        err <= 1'b1;
      end

      if (issue) begin
        for (int unsigned l = 0; l < m; l++) begin
          if (grant[l]) begin
            lane_row[l*IW +: IW] <= job_r;
            lane_col[l*IW +: IW] <= job_c;
          end
        end
        rr     <= (grant_idx == RW'(m - 1)) ? '0 : grant_idx + 1'b1;
        issued <= issued + 1'b1;
        if (job_c == LAST) begin
          job_c <= '0;
          job_r <= job_r + 1'b1;
        end else begin
          job_c <= job_c + 1'b1;
        end
      end

      // Start-time clears are placed after the generic updates so they win.
      case (state)
        IDLE: begin
          if (start_fire) begin
            state     <= DISPATCH;
            jobs_done <= '0;
            err       <= 1'b0;
            issued    <= '0;
            job_r     <= '0;
            job_c     <= '0;
          end
        end
        DISPATCH: begin
          if (last_issue) begin
            state <= (jobs_done_nxt == NN) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (jobs_done_nxt == NN) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.done_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ack = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done_stb  = (state == DONE);
  assign bus.lane_go   = lane_go;
  assign bus.lane_row  = lane_row;
  assign bus.lane_col  = lane_col;
  assign bus.jobs_done = jobs_done;
  assign bus.err       = err;
endmodule
